// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the control unit and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, A, B, input busy, done, hi, lo);
  modport slave  (input start, op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with architectural HI/LO registers.
// Define MULDIV_FAST_MULT_EN to compute MULT/MULTU with a single-cycle multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rstn,
  muldiv_unit_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg;
  logic               is_div_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic [WIDTH-1:0]   a_raw_reg;
  logic [WIDTH-1:0]   mag_a_reg;
  logic [WIDTH-1:0]   mag_b_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  // Operand magnitudes at issue; only MULT (000) and DIV (010) are signed.
  logic             sign_a_in, sign_b_in;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  always_comb begin
    sign_a_in = ~bus.op[0] & bus.A[WIDTH-1];
    sign_b_in = ~bus.op[0] & bus.B[WIDTH-1];
    mag_a_in  = sign_a_in ? (-bus.A) : bus.A;
    mag_b_in  = sign_b_in ? (-bus.B) : bus.B;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] acc_step;
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? mag_a_reg : {WIDTH{1'b0}})};
    div_sh   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff = div_sh - {1'b0, mag_b_reg};
    if (is_div_reg) begin
      if (div_diff[WIDTH]) acc_step = {div_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      else                 acc_step = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  always_comb begin
`ifdef MULDIV_FAST_MULT_EN
    prod = {{WIDTH{1'b0}}, mag_a_reg} * {{WIDTH{1'b0}}, mag_b_reg};
`else
    prod = acc_reg;
`endif
    prod_fix = neg_q_reg ? (-prod) : prod;
    q_fix    = neg_q_reg ? (-acc_reg[WIDTH-1:0]) : acc_reg[WIDTH-1:0];
    r_fix    = neg_r_reg ? (-acc_reg[2*WIDTH-1:WIDTH]) : acc_reg[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      a_raw_reg  <= '0;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (!bus.op[2]) begin
              is_div_reg <= bus.op[1];
              neg_q_reg  <= sign_a_in ^ sign_b_in;
              neg_r_reg  <= sign_a_in;
              a_raw_reg  <= bus.A;
              mag_a_reg  <= mag_a_in;
              mag_b_reg  <= mag_b_in;
              // Multiplier sits in the low half for multiply, dividend for divide.
              acc_reg    <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a_in : mag_b_in)};
              cnt_reg    <= CW'(WIDTH - 1);
              busy_reg   <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
              state_reg  <= bus.op[1] ? CALC : FIX;
`else
              state_reg  <= CALC;
`endif
            end else if (!bus.op[1]) begin
              if (bus.op[0]) lo_reg <= bus.A;
              else           hi_reg <= bus.A;
            end
          end
        end
        CALC: begin
          acc_reg <= acc_step;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == '0) state_reg <= FIX;
        end
        FIX: begin
          if (is_div_reg) begin
            if (mag_b_reg == '0) begin
              hi_reg <= a_raw_reg;
              lo_reg <= '1;
            end else begin
              hi_reg <= r_fix;
              lo_reg <= q_fix;
            end
          end else begin
            {hi_reg, lo_reg} <= prod_fix;
          end
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam int LAT_DIV = W + 2;
`ifdef MULDIV_FAST_MULT_EN
  localparam int LAT_MUL = 2;
`else
  localparam int LAT_MUL = W + 2;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: begin q = sa * sb; return q; end
      3'd1: begin p = ua * ub; return p; end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        p = ua / ub; ub = ua % ub;
        return {ub[31:0], p[31:0]};
      end
    endcase
  endfunction

  // Called at a negedge; issues one op and returns at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cycles, output logic first_busy,
                        output logic busy_at_done);
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    first_busy = bus.busy;
    lat = 1; busy_cycles = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    busy_at_done = bus.busy;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_vec++; if (bus.hi !== '0) begin n_err++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    n_vec++; if (bus.lo !== '0) begin n_err++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
    rstn = 1'b1;
    @(negedge clk);
    $display("reset: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] junk;
    bus.start = 1'b1; bus.op = 3'b100; bus.A = 32'h12345678;
    @(negedge clk);
    hi_m = 32'h12345678;
    n_vec++; if (bus.hi !== hi_m || bus.lo !== lo_m) begin n_err++; $display("FAIL mthi: got hi=%h lo=%h expected hi=%h lo=%h", bus.hi, bus.lo, hi_m, lo_m); end
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL mthi_flags: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    bus.op = 3'b101; bus.A = 32'h9ABCDEF0;
    @(negedge clk);
    lo_m = 32'h9ABCDEF0;
    n_vec++; if (bus.hi !== hi_m || bus.lo !== lo_m) begin n_err++; $display("FAIL mtlo: got hi=%h lo=%h expected hi=%h lo=%h", bus.hi, bus.lo, hi_m, lo_m); end
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL mtlo_flags: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    $display("mthi/mtlo: hi=%h lo=%h", bus.hi, bus.lo);
    // Reserved ops must be ignored.
    junk = $urandom;
    bus.op = 3'b110; bus.A = junk;
    @(negedge clk);
    bus.op = 3'b111;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.hi !== hi_m || bus.lo !== lo_m) begin n_err++; $display("FAIL reserved_op: got hi=%h lo=%h expected hi=%h lo=%h", bus.hi, bus.lo, hi_m, lo_m); end
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL reserved_flags: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    $display("reserved op: hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
  endtask

  task automatic test_reset_mid_div();
    logic saw_done, saw_busy;
    bus.start = 1'b1; bus.op = 3'b100; bus.A = 32'hDEADBEEF;
    @(negedge clk);
    bus.op = 3'b011; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    #1;
    hi_m = '0; lo_m = '0;
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL midreset_flags: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    n_vec++; if (bus.hi !== '0 || bus.lo !== '0) begin n_err++; $display("FAIL midreset_hilo: got hi=%h lo=%h expected 0 0", bus.hi, bus.lo); end
    @(negedge clk);
    rstn = 1'b1;
    saw_done = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
      if (bus.busy === 1'b1) saw_busy = 1'b1;
    end
    n_vec++; if (saw_done !== 1'b0 || saw_busy !== 1'b0) begin n_err++; $display("FAIL midreset_after: got done_seen=%b busy_seen=%b expected 0 0", saw_done, saw_busy); end
    n_vec++; if (bus.hi !== '0 || bus.lo !== '0) begin n_err++; $display("FAIL midreset_hold: got hi=%h lo=%h expected 0 0", bus.hi, bus.lo); end
    $display("reset mid-DIVU: hi=%h lo=%h", bus.hi, bus.lo);
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [10] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd3};
    logic [31:0] t_a  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'h80000000,
                               32'h80000000, 32'd7, 32'h80000000, 32'd7, 32'hFFFFFFFF};
    logic [31:0] t_b  [10] = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd0, 32'hFFFFFFFF,
                               32'd0, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF, 32'd16};
    logic [63:0] t_e  [10] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFF_FFFFFFFD,
                               64'h00000007_FFFFFFFF, 64'h00000000_80000000, 64'h80000000_FFFFFFFF,
                               64'h00000001_FFFFFFFD, 64'h40000000_00000000, 64'hFFFFFFFF_FFFFFFF9,
                               64'h0000000F_0FFFFFFF};
    int lat, bc, elat;
    logic fb, bd;
    for (int i = 0; i < 10; i++) begin
      elat = t_op[i][1] ? LAT_DIV : LAT_MUL;
      run_op(t_op[i], t_a[i], t_b[i], lat, bc, fb, bd);
      hi_m = t_e[i][63:32]; lo_m = t_e[i][31:0];
      n_vec++; if ({bus.hi, bus.lo} !== t_e[i]) begin n_err++; $display("FAIL directed_%0d_result: got %h_%h expected %h", i, bus.hi, bus.lo, t_e[i]); end
      n_vec++; if (lat !== elat || bc !== elat - 1 || fb !== 1'b1 || bd !== 1'b0) begin n_err++;
        $display("FAIL directed_%0d_timing: got lat=%0d busy=%0d first=%b atdone=%b expected %0d %0d 1 0", i, lat, bc, fb, bd, elat, elat - 1); end
      @(negedge clk);
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL directed_%0d_done_pulse: got %b expected 0", i, bus.done); end
      $display("op=%0d A=%h B=%h -> hi=%h lo=%h lat=%0d", t_op[i], t_a[i], t_b[i], bus.hi, bus.lo, lat);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    bus.start = 1'b1; bus.op = 3'b011; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (cyc == 5) begin bus.start = 1'b1; bus.op = 3'b011; bus.A = 32'd1; bus.B = 32'd1; end
      else bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    hi_m = 32'd2; lo_m = 32'd14;
    n_vec++; if (cyc !== LAT_DIV) begin n_err++; $display("FAIL busy_ignore_lat: got %0d expected %0d", cyc, LAT_DIV); end
    n_vec++; if (bus.hi !== hi_m || bus.lo !== lo_m) begin n_err++; $display("FAIL busy_ignore_result: got hi=%h lo=%h expected hi=%h lo=%h", bus.hi, bus.lo, hi_m, lo_m); end
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL busy_ignore_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    $display("DIVU 100/7 with ignored start: hi=%h lo=%h lat=%0d", bus.hi, bus.lo, cyc);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  t_op [3] = '{3'd1, 3'd2, 3'd3};
    logic [31:0] t_a  [3] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7};
    logic [31:0] t_b  [3] = '{32'hFFFFFFFF, 32'd2, 32'd0};
    logic [63:0] e;
    int lat, bc, elat;
    logic fb, bd;
    for (int i = 0; i < 3; i++) begin
      elat = t_op[i][1] ? LAT_DIV : LAT_MUL;
      run_op(t_op[i], t_a[i], t_b[i], lat, bc, fb, bd);
      e = model(t_op[i], t_a[i], t_b[i]);
      hi_m = e[63:32]; lo_m = e[31:0];
      n_vec++; if ({bus.hi, bus.lo} !== e) begin n_err++; $display("FAIL b2b_%0d_result: got %h_%h expected %h", i, bus.hi, bus.lo, e); end
      n_vec++; if (fb !== 1'b1 || lat !== elat) begin n_err++; $display("FAIL b2b_%0d_accept: got first_busy=%b lat=%0d expected 1 %0d", i, fb, lat, elat); end
      $display("back-to-back op=%0d A=%h B=%h -> hi=%h lo=%h lat=%0d", t_op[i], t_a[i], t_b[i], bus.hi, bus.lo, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] e;
    int lat, bc, elat;
    logic fb, bd;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if (o[2]) begin
        bus.start = 1'b1; bus.op = o; bus.A = a;
        @(negedge clk);
        bus.start = 1'b0;
        if (o[0]) lo_m = a; else hi_m = a;
        n_vec++; if (bus.hi !== hi_m || bus.lo !== lo_m || bus.busy !== 1'b0) begin n_err++;
          $display("FAIL random_%0d_mt: got hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0", i, bus.hi, bus.lo, bus.busy, hi_m, lo_m); end
        $display("random op=%0d A=%h -> hi=%h lo=%h", o, a, bus.hi, bus.lo);
      end else begin
        elat = o[1] ? LAT_DIV : LAT_MUL;
        run_op(o, a, b, lat, bc, fb, bd);
        e = model(o, a, b);
        hi_m = e[63:32]; lo_m = e[31:0];
        n_vec++; if ({bus.hi, bus.lo} !== e || lat !== elat) begin n_err++;
          $display("FAIL random_%0d_op%0d: got %h_%h lat=%0d expected %h lat=%0d", i, o, bus.hi, bus.lo, lat, e, elat); end
        $display("random op=%0d A=%h B=%h -> hi=%h lo=%h lat=%0d", o, a, b, bus.hi, bus.lo, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_reset_mid_div();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
